// File: rtl/modport_fifo.sv
// modport_fifo: single-clock FIFO with registered read data and full/empty/almost flags.
// Ports: clk, reset (sync, active-high), i_wren/i_rden/i_wrdata in; o_full/o_empty/o_alm_full/o_alm_empty/o_rddata out.
module modport_fifo #(
    parameter int DATA_W    = 128,
    parameter int DEPTH     = 16,
    parameter int ALM_FULL  = 14,
    parameter int ALM_EMPTY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wren,
    input  logic              i_rden,
    input  logic [DATA_W-1:0] i_wrdata,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty,
    output logic [DATA_W-1:0] o_rddata
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0]   cnt_t;
    typedef logic [AW-1:0] ptr_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t CNT_AF   = cnt_t'(ALM_FULL);
    localparam cnt_t CNT_AE   = cnt_t'(ALM_EMPTY);

    logic [DATA_W-1:0] mem_q [DEPTH];

    ptr_t              wptr_q, wptr_d;
    ptr_t              rptr_q, rptr_d;
    cnt_t              count_q, count_d;
    logic [DATA_W-1:0] rddata_q, rddata_d;

    logic wr_ok;
    logic rd_ok;

    assign o_full      = (count_q == CNT_FULL);
    assign o_empty     = (count_q == '0);
    assign o_alm_full  = (count_q >= CNT_AF);
    assign o_alm_empty = (count_q <= CNT_AE);
    assign o_rddata    = rddata_q;

    always_comb begin
        rd_ok    = i_rden & ~o_empty;
        // a read on the same edge frees a slot, so a full FIFO still accepts
        wr_ok    = i_wren & (~o_full | rd_ok);
        wptr_d   = wptr_q + ptr_t'(wr_ok);
        rptr_d   = rptr_q + ptr_t'(rd_ok);
        rddata_d = rd_ok ? mem_q[rptr_q] : rddata_q;
        count_d  = count_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rddata_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rddata_q <= rddata_d;
        end
    end

    // storage is not cleared by reset; reset only blocks the write
    always_ff @(posedge clk) begin
        if (wr_ok && !reset) begin
            mem_q[wptr_q] <= i_wrdata;
        end
    end

endmodule

// File: tb/tb_modport_fifo.sv
// tb_modport_fifo: queue-model scoreboard bench for modport_fifo.
// Directed scenarios followed by randomized traffic.
module tb_modport_fifo;

    localparam int DATA_W    = 128;
    localparam int DEPTH     = 16;
    localparam int ALM_FULL  = 14;
    localparam int ALM_EMPTY = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_wren = 1'b0;
    logic              i_rden = 1'b0;
    logic [DATA_W-1:0] i_wrdata = '0;
    logic              o_full;
    logic              o_empty;
    logic              o_alm_full;
    logic              o_alm_empty;
    logic [DATA_W-1:0] o_rddata;

    modport_fifo #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .ALM_FULL(ALM_FULL),
        .ALM_EMPTY(ALM_EMPTY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_wren(i_wren),
        .i_rden(i_rden),
        .i_wrdata(i_wrdata),
        .o_full(o_full),
        .o_empty(o_empty),
        .o_alm_full(o_alm_full),
        .o_alm_empty(o_alm_empty),
        .o_rddata(o_rddata)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] last_rd = '0;
    logic              rd_fire = 1'b0;
    logic              rst_fire = 1'b0;
    logic              mon_en = 1'b0;
    int                pass_cnt = 0;
    int                total_cnt = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // Drive one cycle of traffic and advance the model to the post-edge state.
    task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d);
        bit rok, wok;
        @(negedge clk);
        reset    = 1'b0;
        i_wren   = w;
        i_rden   = r;
        i_wrdata = d;
        rok = r && (model_q.size() > 0);
        wok = w && (model_q.size() < DEPTH || rok);
        if (rok) exp_q.push_back(model_q.pop_front());
        if (wok) model_q.push_back(d);
        rd_fire  = rok;
        rst_fire = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        i_wren   = 1'b1;
        i_rden   = 1'b1;
        i_wrdata = 128'hBAD;
        model_q.delete();
        exp_q.delete();
        rd_fire  = 1'b0;
        rst_fire = 1'b1;
        mon_en   = 1'b1;
    endtask

    function automatic logic [DATA_W-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: compares DUT outputs shortly after every active edge.
    initial begin
        int n;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (rst_fire) begin
                    last_rd = '0;
                end else if (rd_fire) begin
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL scoreboard: got empty queue required entry");
                    end else begin
                        last_rd = exp_q.pop_front();
                    end
                end
                n = model_q.size();
                check("rddata", o_rddata, last_rd);
                check("full", DATA_W'(o_full), DATA_W'(n == DEPTH));
                check("empty", DATA_W'(o_empty), DATA_W'(n == 0));
                check("alm_full", DATA_W'(o_alm_full), DATA_W'(n >= ALM_FULL));
                check("alm_empty", DATA_W'(o_alm_empty), DATA_W'(n <= ALM_EMPTY));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        int wp, rp;
        do_reset();
        do_reset();
        repeat (3) step(1'b0, 1'b0, '0);
        // fill to full, then an overflow write
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, DATA_W'(i));
        step(1'b1, 1'b0, 128'hDEAD);
        step(1'b0, 1'b0, '0);
        // drain, then an underflow read
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        // steady occupancy of 8 across pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, rnd());
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, rnd());
        // full with simultaneous read and write
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, rnd());
        step(1'b1, 1'b1, 128'hAA);
        step(1'b1, 1'b0, 128'hBEEF);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, '0);
        // empty with simultaneous read and write: write only
        step(1'b1, 1'b1, 128'h55);
        step(1'b0, 1'b1, '0);
        // reset mid-stream
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd());
        do_reset();
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        // randomized traffic with varying write/read pressure
        for (int b = 0; b < 15; b++) begin
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int i = 0; i < 100; i++) begin
                step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp), rnd());
            end
            if (b == 7) do_reset();
        end
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
